// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle datapath and its controller:
// instruction fields and the ALU zero flag in, datapath control strobes out.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       illegal_op;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  modport master (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op,
    input  result_src, alu_src_a, alu_src_b, imm_src, alu_control, state
  );

  modport slave (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op,
    output result_src, alu_src_a, alu_src_b, imm_src, alu_control, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM controller for a multicycle RV32I subset (lw, sw, R/I-type ALU, beq, jal).
// State-derived strobes are registered alongside the state; input-dependent decodes are combinational.
module multicycle_controller (
  input  logic                         clk,
  input  logic                         reset,
  multicycle_controller_if.slave       bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.ir_write = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; c.pc_update = 1'b1; end
      S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.alu_op = 2'b00; end
      S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b00; end
      S_MEMREAD:  begin c.adr_src = 1'b1; c.result_src = 2'b00; end
      S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      S_EXECUTER: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b00; c.alu_op = 2'b10; end
      S_EXECUTEI: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      S_ALUWB:    begin c.result_src = 2'b00; c.reg_write = 1'b1; end
      S_BEQ:      begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b00; c.alu_op = 2'b01; c.branch = 1'b1; end
      S_JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.alu_op = 2'b00; c.pc_update = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  function automatic logic legal_op(input logic [6:0] o);
    case (o)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  state_t     state_r;
  state_t     next_state_s;
  ctrl_t      ctrl_r;
  logic [2:0] alu_control_s;
  logic [1:0] imm_src_s;
  logic       illegal_op_s;

  // State register; strobes are precomputed from the next state so they leave a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
      ctrl_r  <= state_ctrl(S_FETCH);
    end else begin
      state_r <= next_state_s;
      ctrl_r  <= state_ctrl(next_state_s);
    end
  end

  // Next-state logic; unused encodings fall back to FETCH.
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH:  next_state_s = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
          OP_RTYPE:          next_state_s = S_EXECUTER;
          OP_ITYPE:          next_state_s = S_EXECUTEI;
          OP_BEQ:            next_state_s = S_BEQ;
          OP_JAL:            next_state_s = S_JAL;
          default:           next_state_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (bus.op[5]) next_state_s = S_MEMWRITE;
        else           next_state_s = S_MEMREAD;
      end
      S_MEMREAD:  next_state_s = S_MEMWB;
      S_EXECUTER: next_state_s = S_ALUWB;
      S_EXECUTEI: next_state_s = S_ALUWB;
      S_JAL:      next_state_s = S_ALUWB;
      default:    next_state_s = S_FETCH;
    endcase
  end

  // ALU function select; sub only for R-type with funct7[5] set (I-type addi has no subi).
  always_comb begin
    alu_control_s = 3'b000;
    case (ctrl_r.alu_op)
      2'b00: alu_control_s = 3'b000;
      2'b01: alu_control_s = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000: begin
            if (bus.op[5] && bus.funct7b5) alu_control_s = 3'b001;
            else                           alu_control_s = 3'b000;
          end
          3'b010:  alu_control_s = 3'b101;
          3'b110:  alu_control_s = 3'b011;
          3'b111:  alu_control_s = 3'b010;
          default: alu_control_s = 3'b000;
        endcase
      end
      default: alu_control_s = 3'b000;
    endcase
  end

  // Immediate format select and illegal-opcode flag.
  always_comb begin
    imm_src_s = 2'b00;
    case (bus.op)
      OP_STORE: imm_src_s = 2'b01;
      OP_BEQ:   imm_src_s = 2'b10;
      OP_JAL:   imm_src_s = 2'b11;
      default:  imm_src_s = 2'b00;
    endcase
    if (state_r == S_DECODE) illegal_op_s = ~legal_op(bus.op);
    else                     illegal_op_s = 1'b0;
  end

  assign bus.pc_write    = ctrl_r.pc_update | (ctrl_r.branch & bus.zero);
  assign bus.adr_src     = ctrl_r.adr_src;
  assign bus.mem_write   = ctrl_r.mem_write;
  assign bus.ir_write    = ctrl_r.ir_write;
  assign bus.reg_write   = ctrl_r.reg_write;
  assign bus.illegal_op  = illegal_op_s;
  assign bus.result_src  = ctrl_r.result_src;
  assign bus.alu_src_a   = ctrl_r.alu_src_a;
  assign bus.alu_src_b   = ctrl_r.alu_src_b;
  assign bus.imm_src     = imm_src_s;
  assign bus.alu_control = alu_control_s;
  assign bus.state       = state_r;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock; the only clock.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: op  input  7  instruction opcode, bits [6:0].
REQ-004 SHALL have port: funct3  input  3  instruction bits [14:12].
REQ-005 SHALL have port: funct7b5  input  1  instruction bit 30.
REQ-006 SHALL have port: zero  input  1  ALU zero flag, sampled in BEQ.
REQ-007 SHALL have outputs, each 1 bit: pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op.
REQ-008 SHALL have outputs, each 2 bits: result_src, alu_src_a, alu_src_b, imm_src.
REQ-009 SHALL have port: alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-010 SHALL have port: state  output  4  current FSM state encoding, for debug.

Function
REQ-011 SHALL be a Moore FSM with these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10; codes 11-15 SHALL go to FETCH on the next edge.
REQ-012 SHALL use these transitions:
  - FETCH->DECODE.
  - DECODE, op 0000011 or 0100011 -> MEMADR.
  - DECODE, op 0110011 -> EXECUTER; op 0010011 -> EXECUTEI.
  - DECODE, op 1100011 -> BEQ; op 1101111 -> JAL.
  - DECODE, any other op -> FETCH.
  - MEMADR, op[5]=0 -> MEMREAD; op[5]=1 -> MEMWRITE.
  - MEMREAD->MEMWB; EXECUTER, EXECUTEI and JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
REQ-013 SHALL drive every output not listed for a state to 0; per-state values:
  - FETCH: ir_write=1, alu_src_b=10, result_src=10, pc_update=1.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=00.
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00.
  - MEMREAD: adr_src=1, result_src=00.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1, mem_write=1.
  - EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10.
  - ALUWB: result_src=00, reg_write=1.
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, branch=1.
  - JAL: alu_src_a=01, alu_src_b=10, alu_op=00, pc_update=1.
REQ-014 SHALL compute pc_write = pc_update OR (branch AND zero), combinationally in the same cycle as zero.
REQ-015 SHALL decode alu_control from the internal alu_op:
  - alu_op 00 -> 000; alu_op 01 -> 001; alu_op 11 -> 000.
  - alu_op 10, funct3 000: 001 if op[5] AND funct7b5, else 000.
  - alu_op 10, funct3 010 -> 101; funct3 110 -> 011; funct3 111 -> 010; any other funct3 -> 000.
REQ-016 SHALL decode imm_src combinationally from op in every state: 0100011->01, 1100011->10, 1101111->11, else 00.
REQ-017 SHALL assert illegal_op for exactly the one DECODE cycle holding an unlisted op; the FSM then returns to FETCH with no write asserted.
REQ-018 SHALL produce outputs only from state and the inputs named above: no input-to-state latency beyond one edge, and zero is the only input affecting pc_write.
REQ-019 SHALL give these instruction latencies from FETCH to FETCH: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4 cycles; illegal op 2 cycles.

Reset
REQ-020 SHALL, when reset=1 at a clock edge, load state=FETCH regardless of current state, including mid-instruction; a pending write SHALL NOT be retried.
REQ-021 SHALL, while in FETCH after reset, drive ir_write=1, pc_write=1, alu_src_b=10, result_src=10, state=0 and all other outputs 0.
REQ-022 SHALL give reset priority over all transitions.

Verification
REQ-023 SHALL be covered by: reset held 2 cycles, then released with op=0110011, funct3=000, funct7b5=1 -> states 0,1,6,8,0; alu_control=001 in EXECUTER; reg_write=1 only in ALUWB.
REQ-024 SHALL be covered by: lw (op=0000011) -> states 0,1,2,3,4,0; adr_src=1 in MEMREAD; result_src=01 and reg_write=1 in MEMWB; imm_src=00.
REQ-025 SHALL be covered by: beq with zero=1 -> pc_write=1 in BEQ; with zero=0 -> pc_write=0; alu_control=001; imm_src=10; next state FETCH in both cases.
REQ-026 SHALL be covered by: op=1111111 -> illegal_op=1 for one cycle in DECODE, then state=0, with mem_write and reg_write never set.
REQ-027 SHALL be covered by: reset asserted in MEMWRITE -> state=0 on the next edge, mem_write=0 from that cycle on.
REQ-028 SHALL be covered by: op=0010011 with funct3=010, then 110, then 111 -> alu_control 101, 011, 010 respectively in EXECUTEI; funct3=000 with funct7b5=1 -> 000.
